// File: rtl/keypad_pkg.sv
// Shared types, widths and line-encoding helpers for the keypad emulator,
// scanner and key converter.
package keypad_pkg;

    localparam int KEY_W  = 4;
    localparam int LINE_W = 4;
    localparam int CNT_W  = 16;

    localparam logic [LINE_W-1:0] LINES_IDLE = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_COL,
        HOLD,
        GAP
    } state_e;

    // Active-low column drive that selects column c (column 0 = 4'b0111).
    function automatic logic [LINE_W-1:0] col_select(input logic [1:0] c);
        return ~(LINE_W'(4'b1000) >> c);
    endfunction

    // Active-low row pattern for row r; row r lives on line bit (3-r).
    function automatic logic [LINE_W-1:0] row_bit(input logic [1:0] r);
        return ~(LINE_W'(4'b1000) >> r);
    endfunction

endpackage

// File: rtl/keypad_bounce_gen.sv
// Contact-bounce gate: after a HOLD-entry strobe, gate_o alternates 1,0,1,0...
// for BOUNCE_CYCLES clocks, then stays 1.
module keypad_bounce_gen
    import keypad_pkg::*;
#(
    parameter int BOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic start_i,
    output logic gate_o
);

    localparam logic [CNT_W-1:0] BNC_LAST = CNT_W'(BOUNCE_CYCLES - 1);

    logic             active_q, active_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        if (start_i) begin
            active_d = (BOUNCE_CYCLES > 0);
            cnt_d    = '0;
        end else if (active_q) begin
            if (cnt_q == BNC_LAST) active_d = 1'b0;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
        end
    end

    // Even burst cycles let the row assert, odd ones release it.
    assign gate_o = !active_q || !cnt_q[0];

endmodule

// File: rtl/keypad_emulator.sv
// Row-driving side of the 4x4 keypad matrix: presses a scripted key when the
// scanner drives its column. Optional bounce burst: define KEYPAD_EMU_BOUNCE_EN.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int HOLD_CYCLES   = 16,
    parameter int GAP_CYCLES    = 8,
    parameter int SCAN_TIMEOUT  = 64,
    parameter int BOUNCE_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [LINE_W-1:0] Cols,
    input  logic [KEY_W-1:0]  key_code,
    input  logic              press_req,
    output logic [LINE_W-1:0] Rows,
    output logic              busy,
    output logic              done,
    output logic              timeout
);

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 65535 ||
        GAP_CYCLES < 1 || GAP_CYCLES > 65535 ||
        SCAN_TIMEOUT < 1 || SCAN_TIMEOUT > 65535 ||
        BOUNCE_CYCLES < 0 || BOUNCE_CYCLES > 65535) begin : g_param_check
        $error("keypad_emulator: cycle parameters must fit the 16-bit counter");
    end

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(SCAN_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [KEY_W-1:0] code_q, code_d;
    logic             col_match;
    logic             gate;

    // Non-one-hot drives can never equal a col_select pattern, so they never match.
    assign col_match = (Cols == col_select(code_q[1:0]));

`ifdef KEYPAD_EMU_BOUNCE_EN
    logic hold_start;
    assign hold_start = (state_q == WAIT_COL) && col_match;

    keypad_bounce_gen #(
        .BOUNCE_CYCLES(BOUNCE_CYCLES)
    ) u_bounce (
        .clock  (clock),
        .reset  (reset),
        .start_i(hold_start),
        .gate_o (gate)
    );
`else
    assign gate = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        done    = 1'b0;
        timeout = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (press_req) begin
                    code_d  = key_code;
                    cnt_d   = '0;
                    state_d = WAIT_COL;
                end
            end
            WAIT_COL: begin
                // A match in the timeout cycle still wins.
                if (col_match) begin
                    cnt_d   = '0;
                    state_d = HOLD;
                end else if (cnt_q == TO_LAST) begin
                    timeout = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    done    = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign Rows = (state_q == HOLD && col_match && gate) ? row_bit(code_q[3:2]) : LINES_IDLE;

endmodule

// File: tb/tb_keypad_emulator.sv
// Randomized scoreboard bench for keypad_emulator: a transaction-level model
// queues per-cycle expectations, a negedge monitor pops and compares them.
module tb_keypad_emulator;

    localparam int HOLD = 16;
    localparam int GAP  = 8;
    localparam int TO   = 64;
    localparam int BNC  = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] Cols, key_code, Rows;
    logic       press_req, busy, done, timeout;

    typedef struct packed {
        logic [3:0] rows;
        logic       busy;
        logic       done;
        logic       tmo;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc_no = 0;

    keypad_emulator #(
        .HOLD_CYCLES  (HOLD),
        .GAP_CYCLES   (GAP),
        .SCAN_TIMEOUT (TO),
        .BOUNCE_CYCLES(BNC)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .Cols     (Cols),
        .key_code (key_code),
        .press_req(press_req),
        .Rows     (Rows),
        .busy     (busy),
        .done     (done),
        .timeout  (timeout)
    );

    always #5 clock = ~clock;

    function automatic logic [3:0] colpat(input int c);
        logic [3:0] one = 4'b1000;
        return 4'b1111 ^ (one >> c);
    endfunction

    function automatic logic [3:0] rowpat(input int r);
        logic [3:0] one = 4'b1000;
        return 4'b1111 ^ (one >> r);
    endfunction

    function automatic exp_t mk(input logic [3:0] r, input logic b, input logic d, input logic t);
        exp_t e;
        e.rows = r; e.busy = b; e.done = d; e.tmo = t;
        return e;
    endfunction

    // Row visibly asserted in HOLD cycle h (bounce burst when built with the macro).
    function automatic logic hold_gate(input int h);
`ifdef KEYPAD_EMU_BOUNCE_EN
        return (h >= BNC) || (h % 2 == 0);
`else
        return (h >= 0);
`endif
    endfunction

    // Scanner column drive for transaction-relative cycle t.
    // 0 rotate, 1 never match (random), 2 freeze on match after d cycles,
    // 3 random, 4 stuck at 4'b1111.
    function automatic logic [3:0] gen_cols(input int mode, input int t, input int d,
                                            input logic [3:0] mp);
        logic [3:0] rot [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
        logic [3:0] v;
        case (mode)
            0: v = rot[t % 4];
            1, 2: begin
                v = 4'($urandom);
                if (v == mp) v = 4'b1111;
                if (mode == 2 && t >= d) v = mp;
            end
            3: v = ($urandom_range(0, 1) == 1) ? colpat($urandom_range(0, 3)) : 4'($urandom);
            default: v = 4'b1111;
        endcase
        return v;
    endfunction

    task automatic step(input logic [3:0] c, input logic req, input logic [3:0] code, input exp_t e);
        Cols = c; press_req = req; key_code = code;
        expq.push_back(e);
        @(posedge clock); #1;
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, got, want);
        end
    endtask

    task automatic press(input logic [3:0] code, input int mode, input bit hold_req);
        logic [3:0] mp = colpat(int'(code[1:0]));
        logic [3:0] rp = rowpat(int'(code[3:2]));
        logic [3:0] c;
        int  d = $urandom_range(0, 10);
        int  t = 0;
        bit  matched = 0;
        step(4'($urandom), 1'b1, code, mk(4'b1111, 0, 0, 0));
        for (int w = 0; w < TO && !matched; w++) begin
            c = gen_cols(mode, t++, d, mp);
            matched = (c == mp);
            step(c, hold_req | 1'($urandom), 4'($urandom),
                 mk(4'b1111, 1, 0, !matched && w == TO - 1));
        end
        if (matched) begin
            for (int h = 0; h < HOLD; h++) begin
                c = gen_cols(mode, t++, d, mp);
                step(c, hold_req | 1'($urandom), 4'($urandom),
                     mk((c == mp && hold_gate(h)) ? rp : 4'b1111, 1, 0, 0));
            end
            for (int g = 0; g < GAP; g++)
                step(gen_cols(mode, t++, d, mp), hold_req | 1'($urandom), 4'($urandom),
                     mk(4'b1111, 1, g == GAP - 1, 0));
        end
    endtask

    task automatic reset_mid_hold(input logic [3:0] code);
        logic [3:0] mp = colpat(int'(code[1:0]));
        logic [3:0] rp = rowpat(int'(code[3:2]));
        step(4'b1111, 1'b1, code, mk(4'b1111, 0, 0, 0));
        step(mp, 1'b0, code, mk(4'b1111, 1, 0, 0));
        for (int h = 0; h < 4; h++)
            step(mp, 1'b0, code, mk(hold_gate(h) ? rp : 4'b1111, 1, 0, 0));
        // Fifth HOLD cycle: no queued expectation, checked directly.
        #1;
        chk("hold5_rows_before_reset", {4'b0, Rows}, {4'b0, rp});
        reset = 1'b1;
        #1;
        chk("reset_async_rows", {4'b0, Rows}, 8'h0F);
        chk("reset_async_flags", {5'b0, busy, done, timeout}, 8'h00);
        @(posedge clock); #1;
        chk("reset_held_flags", {Rows, 1'b0, busy, done, timeout}, 8'hF0);
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    always @(negedge clock) begin
        cyc_no++;
        if (expq.size() > 0) begin
            mon_e = expq.pop_front();
            checks++;
            if ({Rows, busy, done, timeout} !== mon_e) begin
                errors++;
                $display("FAIL cycle_check @%0d: got rows=%b busy=%b done=%b timeout=%b, expected rows=%b busy=%b done=%b timeout=%b",
                         cyc_no, Rows, busy, done, timeout, mon_e.rows, mon_e.busy, mon_e.done, mon_e.tmo);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; Cols = 4'b1111; press_req = 1'b0; key_code = 4'b0000;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_state", {Rows, 1'b0, busy, done, timeout}, 8'hF0);
        reset = 1'b0;

        press(4'b0110, 0, 1'b0);   // rotating scan
        press(4'b0000, 4, 1'b0);   // stuck columns -> timeout
        step(4'b1111, 1'b0, 4'b0000, mk(4'b1111, 0, 0, 0));
        press(4'b1111, 2, 1'b0);   // scanner freezes on match
        reset_mid_hold(4'b1001);
        press(4'b0101, 2, 1'b0);   // normal completion after reset
        press(4'b0110, 2, 1'b1);   // back-to-back, key_code churn while busy
        press(4'b1011, 0, 1'b1);
        press(4'b0010, 1, 1'b0);   // random non-matching drive -> timeout

        for (int i = 0; i < 30; i++) begin
            press(4'($urandom), $urandom_range(0, 4), 1'($urandom));
            if ($urandom_range(0, 2) == 0)
                step(4'($urandom), 1'b0, 4'($urandom), mk(4'b1111, 0, 0, 0));
        end
        step(4'b1111, 1'b0, 4'b0000, mk(4'b1111, 0, 0, 0));
        step(4'b1111, 1'b0, 4'b0000, mk(4'b1111, 0, 0, 0));
        @(negedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
- Behavioural keypad model for the calculator: the row-driving end of the 4x4 matrix interface that the keypad scanner reads.
- Takes a scripted key press (key code plus request/acknowledge handshake), watches the scanner's active-low column drive, and pulls the matching row low for a fixed hold time.
- Used in simulation benches and for on-board self-test injection in place of the physical keypad.

Parameters:
- HOLD_CYCLES, 16, clocks the row is held low once the matching column is first seen (1..65535).
- GAP_CYCLES, 8, clocks all rows stay released after a press before done.
- SCAN_TIMEOUT, 64, clocks to wait for a column match before aborting.
- BOUNCE_CYCLES, 4, length of the bounce burst (used only with KEYPAD_EMU_BOUNCE_EN).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Cols  in  4  scanner column drive; exactly one bit low selects a column.
- key_code  in  4  key to press: row = key_code[3:2], col = key_code[1:0].
- press_req  in  1  request; sampled only in IDLE.
- Rows  out  4  row lines to scanner, active-low; 4'b1111 = no key.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a press completes normally.
- timeout  out  1  one-cycle pulse when SCAN_TIMEOUT expires with no column match.

Behaviour:
- Reset values: Rows=4'b1111, busy=0, done=0, timeout=0, state=IDLE, counter=0, latched code=0.
- Column c is selected when Cols == ~(4'b1000 >> c); column 0 corresponds to Cols=4'b0111.
- Row r is driven by Rows bit (3-r).
- Rows is combinational:
  - In HOLD, row r bit is 0 while Cols selects column c, otherwise 1.
  - All other states: Rows=4'b1111.
  - Models a real switch: if Cols moves off column c, the row releases in the same cycle.
- Cols values that are not one-hot-low (e.g. 4'b1111, 4'b0011) never count as a match.
- FSM:
  - IDLE: when press_req=1, latch key_code, clear counter, go to WAIT_COL. The latched code is used for the whole transaction; later key_code changes are ignored.
  - WAIT_COL: counter increments each clock.
    - If Cols selects the latched column: go to HOLD and clear the counter. Rows asserts in the first HOLD cycle, which is one clock after the match is seen.
    - Else if counter reaches SCAN_TIMEOUT-1: pulse timeout, return to IDLE.
    - If a match and the timeout fall in the same cycle, the match wins.
  - HOLD: counter increments every clock whether or not the column currently matches. At HOLD_CYCLES-1, clear the counter and go to GAP.
  - GAP: Rows=4'b1111. At GAP_CYCLES-1, pulse done and go to IDLE.
- Latency: done is asserted exactly HOLD_CYCLES+GAP_CYCLES clocks after the HOLD entry edge.
- press_req is ignored while busy; no queueing.
- press_req held high continuously gives back-to-back presses; each new press begins on the first IDLE cycle after done.
- Reset asserted mid-operation (any state):
  - Rows=4'b1111 immediately (asynchronous), state returns to IDLE.
  - No done or timeout pulse is emitted.
- Counter is 16 bits wide; parameters above 65535 are illegal and must be rejected by an elaboration-time check.

Optional Feature:
- Macro: KEYPAD_EMU_BOUNCE_EN.
- Defined:
  - For the first BOUNCE_CYCLES clocks of HOLD, the asserted row is gated by a toggling bit, so it reads low, high, low, high...
  - The toggle starts low in the first HOLD cycle.
  - Column matching applies as normal during the burst.
  - The HOLD counter still counts from HOLD entry, so total HOLD length is unchanged.
- Undefined: the row is solid low for the whole of HOLD; the BOUNCE_CYCLES parameter has no effect.

Decomposition:
- Package keypad_pkg:
  - state enum: IDLE, WAIT_COL, HOLD, GAP.
  - widths: KEY_W=4, LINE_W=4, CNT_W=16.
  - idle line constant LINES_IDLE=4'b1111.
  - functions col_select(c) and row_bit(r), shared with the scanner and the key converter.
- Sub-module keypad_bounce_gen: produces the toggle gate from a HOLD-entry strobe.
  - Instantiated only under KEYPAD_EMU_BOUNCE_EN.
  - Without the macro, the gate is tied to 1.

Test Plan:
- Press with key_code=4'b0110, Cols rotating 0111→1011→1101→1110 one step per clock -> Rows=4'b1011 only during HOLD cycles where Cols=4'b1101; done pulse 24 clocks after HOLD entry (defaults).
- Cols held at 4'b1111, press_req with key_code=4'b0000 -> no Rows activity; timeout pulse on the 64th WAIT_COL clock; busy drops on the next cycle.
- Scanner model freezes Cols at the match, key_code=4'b1111 -> Rows=4'b1110 for exactly 16 consecutive clocks, then 4'b1111 for 8 clocks, then done.
- Reset asserted on the 5th HOLD cycle -> Rows=4'b1111 the same instant, busy=0, no done pulse; a new press_req afterwards completes normally.
- press_req held high, key_code changed during HOLD -> first press uses the original code; second press starts in the cycle after done and uses the new code.
- KEYPAD_EMU_BOUNCE_EN defined, BOUNCE_CYCLES=4 -> matched row reads 0,1,0,1 over the first 4 HOLD clocks, then solid 0 for the remaining 12.
